// File: rtl/uart_cmd_frame_pkg.sv
// Shared definitions for the UART command-frame decoder: state encoding,
// default framing bytes and the frame checksum.
package uart_cmd_frame_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [7:0] DEF_HDR_BYTE  = 8'hA5;
  localparam logic [7:0] DEF_TAIL_BYTE = 8'h5A;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_GET_CMD  = 3'd1;
  localparam logic [2:0] ST_GET_ARG  = 3'd2;
  localparam logic [2:0] ST_GET_CHK  = 3'd3;
  localparam logic [2:0] ST_GET_TAIL = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    GET_CMD  = ST_GET_CMD,
    GET_ARG  = ST_GET_ARG,
    GET_CHK  = ST_GET_CHK,
    GET_TAIL = ST_GET_TAIL
  } frame_state_e;

  // Checksum byte carried by a frame: XOR of command and argument.
  function automatic logic [BYTE_W-1:0] frame_checksum(input logic [BYTE_W-1:0] cmd,
                                                       input logic [BYTE_W-1:0] arg);
    return cmd ^ arg;
  endfunction

endpackage

// File: rtl/uart_cmd_frame_if.sv
// Byte stream from uart_rx plus the decoded command outputs.
// UART_CMD_FRAME_ERRCNT_EN adds the saturating err_cnt signal.
interface uart_cmd_frame_if;
  import uart_cmd_frame_pkg::*;

  logic [BYTE_W-1:0] po_data;
  logic              rx_down;
  logic [BYTE_W-1:0] cmd_code;
  logic [BYTE_W-1:0] cmd_arg;
  logic              cmd_valid;
  logic              frame_err;
  logic              busy;
`ifdef UART_CMD_FRAME_ERRCNT_EN
  logic [7:0]        err_cnt;

  modport master (output po_data, rx_down,
                  input  cmd_code, cmd_arg, cmd_valid, frame_err, busy, err_cnt);
  modport slave  (input  po_data, rx_down,
                  output cmd_code, cmd_arg, cmd_valid, frame_err, busy, err_cnt);
`else
  modport master (output po_data, rx_down,
                  input  cmd_code, cmd_arg, cmd_valid, frame_err, busy);
  modport slave  (input  po_data, rx_down,
                  output cmd_code, cmd_arg, cmd_valid, frame_err, busy);
`endif
endinterface

// File: rtl/frame_timeout_cnt.sv
// Inter-byte timeout counter; tc_c pulses when an enabled, uncleared count
// reaches TIMEOUT_CYC-1, and the count restarts from zero.
module frame_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  assign tc_c = enable && !clear && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tc_c) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_frame.sv
// 5-byte command-frame decoder (header, cmd, arg, checksum, tail) behind uart_rx.
// Optional UART_CMD_FRAME_ERRCNT_EN adds a saturating frame-error counter.
module uart_cmd_frame
  import uart_cmd_frame_pkg::*;
#(
  parameter logic [7:0]  HDR_BYTE    = DEF_HDR_BYTE,
  parameter logic [7:0]  TAIL_BYTE   = DEF_TAIL_BYTE,
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_cmd_frame_if.slave  bus
);

  frame_state_e      state;
  logic [BYTE_W-1:0] cmd_shadow;
  logic [BYTE_W-1:0] arg_shadow;
  logic [BYTE_W-1:0] cmd_code;
  logic [BYTE_W-1:0] cmd_arg;
  logic              cmd_valid;
  logic              frame_err;
  logic              busy;
  logic              timeout_c;
  logic              to_clear_c;
  logic              to_enable_c;

  // A byte strobe always restarts the timeout, so a byte on the terminal cycle wins.
  assign to_clear_c  = (state == IDLE) || bus.rx_down;
  assign to_enable_c = (state != IDLE);

  frame_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (to_clear_c),
    .enable (to_enable_c),
    .tc_c   (timeout_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_shadow <= '0;
      arg_shadow <= '0;
      cmd_code   <= '0;
      cmd_arg    <= '0;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      if (bus.rx_down) begin
        unique case (state)
          IDLE: begin
            if (bus.po_data == HDR_BYTE) begin
              state <= GET_CMD;
              busy  <= 1'b1;
            end
          end
          GET_CMD: begin
            cmd_shadow <= bus.po_data;
            state      <= GET_ARG;
          end
          GET_ARG: begin
            arg_shadow <= bus.po_data;
            state      <= GET_CHK;
          end
          GET_CHK: begin
            if (bus.po_data == frame_checksum(cmd_shadow, arg_shadow)) begin
              state <= GET_TAIL;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
            end
          end
          GET_TAIL: begin
            if (bus.po_data == TAIL_BYTE) begin
              cmd_code  <= cmd_shadow;
              cmd_arg   <= arg_shadow;
              cmd_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (timeout_c) begin
        frame_err <= 1'b1;
        state     <= IDLE;
        busy      <= 1'b0;
      end
    end
  end

  assign bus.cmd_code  = cmd_code;
  assign bus.cmd_arg   = cmd_arg;
  assign bus.cmd_valid = cmd_valid;
  assign bus.frame_err = frame_err;
  assign bus.busy      = busy;

`ifdef UART_CMD_FRAME_ERRCNT_EN
  logic [7:0] err_cnt;

  // Counts frame_err pulses one cycle after they appear; sticks at 8'hFF.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (frame_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'(1);
    end
  end

  assign bus.err_cnt = err_cnt;
`endif

endmodule

// File: tb/tb_uart_cmd_frame.sv
// Directed self-checking bench for uart_cmd_frame (TIMEOUT_CYC=100).
// Covers UART_CMD_FRAME_ERRCNT_EN saturation when that macro is defined.
`timescale 1ns/1ps
module tb_uart_cmd_frame;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   valid_seen;
  int   err_seen;
  int   both_seen;

  uart_cmd_frame_if bus ();

  uart_cmd_frame #(
    .HDR_BYTE    (8'hA5),
    .TAIL_BYTE   (8'h5A),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.cmd_valid === 1'b1) valid_seen <= valid_seen + 1;
    if (bus.frame_err === 1'b1) err_seen <= err_seen + 1;
    if (bus.cmd_valid === 1'b1 && bus.frame_err === 1'b1) both_seen <= both_seen + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    bus.po_data = b;
    bus.rx_down = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_down = 1'b0;
    bus.po_data = 8'h00;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.rx_down = 1'b0;
    bus.po_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.cmd_code !== 8'h00 || bus.cmd_arg !== 8'h00) begin
      failures++;
      $display("FAIL reset_cmd: got %h/%h want 00/00", bus.cmd_code, bus.cmd_arg);
    end
    checks++;
    if (bus.cmd_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: valid=%b err=%b busy=%b want 0/0/0",
               bus.cmd_valid, bus.frame_err, bus.busy);
    end
    rst_n = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_valid_frame;
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    send_byte(8'hA5);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_hdr: got %b want 1", bus.busy);
    end
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h26); send_byte(8'h5A);
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 8'h12 || bus.cmd_arg !== 8'h34) begin
      failures++;
      $display("FAIL valid_frame: valid=%b code=%h arg=%h want 1/12/34",
               bus.cmd_valid, bus.cmd_code, bus.cmd_arg);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_tail: got %b want 0", bus.busy);
    end
    idle_cycles(1);
    checks++;
    if (bus.cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL valid_one_cycle: got %b want 0", bus.cmd_valid);
    end
    idle_cycles(1);
    checks++;
    if (valid_seen - v0 !== 1 || err_seen - e0 !== 0) begin
      failures++;
      $display("FAIL valid_pulses: valid=%0d err=%0d want 1/0", valid_seen - v0, err_seen - e0);
    end
  endtask

  task automatic test_bad_checksum;
    int v0;
    v0 = valid_seen;
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h27);
    checks++;
    if (bus.frame_err !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL bad_chk: err=%b busy=%b want 1/0", bus.frame_err, bus.busy);
    end
    checks++;
    if (bus.cmd_code !== 8'h12 || bus.cmd_arg !== 8'h34) begin
      failures++;
      $display("FAIL bad_chk_hold: code=%h arg=%h want 12/34", bus.cmd_code, bus.cmd_arg);
    end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h5A);
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 8'h01 || bus.cmd_arg !== 8'h02) begin
      failures++;
      $display("FAIL after_err_frame: valid=%b code=%h arg=%h want 1/01/02",
               bus.cmd_valid, bus.cmd_code, bus.cmd_arg);
    end
    idle_cycles(2);
    checks++;
    if (valid_seen - v0 !== 1) begin
      failures++;
      $display("FAIL bad_chk_valid_count: got %0d want 1", valid_seen - v0);
    end
  endtask

  task automatic test_bad_tail;
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h26); send_byte(8'h00);
    checks++;
    if (bus.frame_err !== 1'b1 || bus.cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL bad_tail: err=%b valid=%b want 1/0", bus.frame_err, bus.cmd_valid);
    end
    idle_cycles(2);
    checks++;
    if (valid_seen - v0 !== 0 || err_seen - e0 !== 1 ||
        bus.cmd_code !== 8'h01 || bus.cmd_arg !== 8'h02) begin
      failures++;
      $display("FAIL bad_tail_state: valid=%0d err=%0d code=%h arg=%h want 0/1/01/02",
               valid_seen - v0, err_seen - e0, bus.cmd_code, bus.cmd_arg);
    end
  endtask

  task automatic test_timeout;
    int n;
    int e0;
    send_byte(8'hA5); send_byte(8'h12);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (bus.frame_err === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n !== 100) begin
      failures++;
      $display("FAIL timeout_latency: got %0d cycles want 100", n);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_busy: got %b want 0", bus.busy);
    end
    idle_cycles(2);
    // Byte arriving exactly on the terminal-count cycle is processed instead.
    e0 = err_seen;
    send_byte(8'hA5); send_byte(8'h12);
    repeat (99) @(posedge clk);
    #1;
    send_byte(8'h34);
    checks++;
    if (bus.frame_err !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL tc_byte_wins: err=%b busy=%b want 0/1", bus.frame_err, bus.busy);
    end
    send_byte(8'h26); send_byte(8'h5A);
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 8'h12 || bus.cmd_arg !== 8'h34) begin
      failures++;
      $display("FAIL tc_frame: valid=%b code=%h arg=%h want 1/12/34",
               bus.cmd_valid, bus.cmd_code, bus.cmd_arg);
    end
    idle_cycles(2);
    checks++;
    if (err_seen - e0 !== 0) begin
      failures++;
      $display("FAIL tc_no_err: got %0d errors want 0", err_seen - e0);
    end
  endtask

  task automatic test_junk;
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL junk_busy: got %b want 0", bus.busy);
    end
    idle_cycles(2);
    checks++;
    if (valid_seen - v0 !== 0 || err_seen - e0 !== 0) begin
      failures++;
      $display("FAIL junk_pulses: valid=%0d err=%0d want 0/0", valid_seen - v0, err_seen - e0);
    end
  endtask

  task automatic test_reset_midframe;
    int v0, e0;
    send_byte(8'hA5); send_byte(8'h12);
    rst_n = 1'b0;
    idle_cycles(2);
    rst_n = 1'b1;
    v0 = valid_seen; e0 = err_seen;
    checks++;
    if (bus.cmd_code !== 8'h00 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL midframe_reset: code=%h busy=%b want 00/0", bus.cmd_code, bus.busy);
    end
    send_byte(8'hA5); send_byte(8'h55); send_byte(8'h66); send_byte(8'h33); send_byte(8'h5A);
    idle_cycles(2);
    checks++;
    if (valid_seen - v0 !== 1 || err_seen - e0 !== 0 ||
        bus.cmd_code !== 8'h55 || bus.cmd_arg !== 8'h66) begin
      failures++;
      $display("FAIL midframe_next: valid=%0d err=%0d code=%h arg=%h want 1/0/55/66",
               valid_seen - v0, err_seen - e0, bus.cmd_code, bus.cmd_arg);
    end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = valid_seen;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h5A);
    send_byte(8'hA5); send_byte(8'h0F); send_byte(8'hF0); send_byte(8'hFF); send_byte(8'h5A);
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 8'h0F || bus.cmd_arg !== 8'hF0) begin
      failures++;
      $display("FAIL b2b_second: valid=%b code=%h arg=%h want 1/0F/F0",
               bus.cmd_valid, bus.cmd_code, bus.cmd_arg);
    end
    // Header and tail values inside a frame are ordinary data.
    send_byte(8'hA5); send_byte(8'hA5); send_byte(8'h5A); send_byte(8'hFF); send_byte(8'h5A);
    checks++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 8'hA5 || bus.cmd_arg !== 8'h5A) begin
      failures++;
      $display("FAIL hdr_as_data: valid=%b code=%h arg=%h want 1/A5/5A",
               bus.cmd_valid, bus.cmd_code, bus.cmd_arg);
    end
    idle_cycles(2);
    checks++;
    if (valid_seen - v0 !== 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d want 3", valid_seen - v0);
    end
  endtask

`ifdef UART_CMD_FRAME_ERRCNT_EN
  task automatic test_err_cnt;
    for (int i = 0; i < 260; i++) begin
      send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
    end
    idle_cycles(2);
    checks++;
    if (bus.err_cnt !== 8'hFF) begin
      failures++;
      $display("FAIL err_cnt_sat: got %h want FF", bus.err_cnt);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    valid_seen = 0;
    err_seen = 0;
    both_seen = 0;
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_bad_tail();
    test_timeout();
    test_junk();
    test_reset_midframe();
    test_back_to_back();
`ifdef UART_CMD_FRAME_ERRCNT_EN
    test_err_cnt();
`endif
    checks++;
    if (both_seen !== 0) begin
      failures++;
      $display("FAIL valid_and_err_same_cycle: got %0d want 0", both_seen);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
